serial_word_cmp: RTL and testbench

SERIAL_WORD_CMP -- requirements
Module: serial_word_cmp

---
 rtl/serial_word_cmp.sv | 108 ++++++++++
 tb/tb_serial_word_cmp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_cmp.sv
// Serial MSB-first comparator of two words delivered as 2-bit digit pairs.
// Reports a==b / a>b / a<b one cycle after the last pair is accepted.
module serial_word_cmp #(
  parameter int MAX_DIGITS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       din_valid,
  input  logic [1:0] a_dig,
  input  logic [1:0] b_dig,
  input  logic       din_last,
  output logic       din_ready,
  output logic       busy,
  output logic       done,
  output logic       aeqb,
  output logic       agtb,
  output logic       altb,
  output logic       err,
  output logic [4:0] digit_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] LAST_IDX = 5'(MAX_DIGITS - 1);

  logic [1:0] state;
  logic       eq_acc;
  logic       gt_acc;
  logic       lt_acc;
  logic       xfer;
  logic       eq_nxt;
  logic       gt_nxt;
  logic       lt_nxt;
  logic       at_max;

  assign din_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign xfer      = din_valid & din_ready;
  assign at_max    = (digit_cnt == LAST_IDX);

  // Only the first differing digit (MSB side) may set gt/lt.
  always_comb begin
    eq_nxt = eq_acc;
    gt_nxt = gt_acc;
    lt_nxt = lt_acc;
    if (eq_acc && (a_dig != b_dig)) begin
      eq_nxt = 1'b0;
      gt_nxt = (a_dig > b_dig);
      lt_nxt = (a_dig < b_dig);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      eq_acc    <= 1'b1;
      gt_acc    <= 1'b0;
      lt_acc    <= 1'b0;
      done      <= 1'b0;
      aeqb      <= 1'b0;
      agtb      <= 1'b0;
      altb      <= 1'b0;
      err       <= 1'b0;
      digit_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            eq_acc    <= 1'b1;
            gt_acc    <= 1'b0;
            lt_acc    <= 1'b0;
            err       <= 1'b0;
            digit_cnt <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            digit_cnt <= digit_cnt + 5'd1;
            eq_acc    <= eq_nxt;
            gt_acc    <= gt_nxt;
            lt_acc    <= lt_nxt;
            // Results land together with done in the DONE cycle.
            if (din_last || at_max) begin
              state <= DONE;
              done  <= 1'b1;
              aeqb  <= eq_nxt;
              agtb  <= gt_nxt;
              altb  <= lt_nxt;
              err   <= ~din_last;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_cmp.sv
// Directed and randomized checks of serial_word_cmp against a
// whole-word arithmetic reference model.
module tb_serial_word_cmp;

  localparam int MAXD = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       din_valid = 1'b0;
  logic [1:0] a_dig = '0;
  logic [1:0] b_dig = '0;
  logic       din_last = 1'b0;
  logic       din_ready;
  logic       busy;
  logic       done;
  logic       aeqb;
  logic       agtb;
  logic       altb;
  logic       err;
  logic [4:0] digit_cnt;

  int checks = 0;
  int failures = 0;
  int da[16];
  int db[16];
  bit p_eq, p_gt, p_lt, p_err;
  int p_cnt;

  serial_word_cmp #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .din_valid(din_valid),
    .a_dig(a_dig),
    .b_dig(b_dig),
    .din_last(din_last),
    .din_ready(din_ready),
    .busy(busy),
    .done(done),
    .aeqb(aeqb),
    .agtb(agtb),
    .altb(altb),
    .err(err),
    .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ready"}, 32'(din_ready), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".aeqb"}, 32'(aeqb), 0);
    chk({tag, ".agtb"}, 32'(agtb), 0);
    chk({tag, ".altb"}, 32'(altb), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".cnt"}, 32'(digit_cnt), 0);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, ".aeqb"}, 32'(aeqb), 32'(p_eq));
    chk({tag, ".agtb"}, 32'(agtb), 32'(p_gt));
    chk({tag, ".altb"}, 32'(altb), 32'(p_lt));
  endtask

  // n pairs from da/db; last flag on pair n-1 when use_last.
  task automatic do_cmp(input string tag, input int n,
                        input int gap, input bit use_last,
                        input bit noise, input bit vw_start);
    longint aw, bw;
    int m;
    @(negedge clk);
    start = 1'b1;
    din_valid = vw_start;
    a_dig = 2'(da[0]);
    b_dig = 2'(db[0]);
    din_last = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din_valid = 1'b0;
    din_last = 1'b0;
    chk({tag, ".run_busy"}, 32'(busy), 1);
    chk({tag, ".run_cnt"}, 32'(digit_cnt), 0);
    chk_held({tag, ".run_hold"});
    for (int i = 0; i < n; i++) begin
      a_dig = 2'(da[i]);
      b_dig = 2'(db[i]);
      din_last = use_last && (i == n - 1);
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      din_last = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = noise;
          a_dig = 2'($urandom);
          b_dig = 2'($urandom);
          chk({tag, ".gap_done"}, 32'(done), 0);
          chk({tag, ".gap_cnt"}, 32'(digit_cnt), 32'(i + 1));
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    m = (n > MAXD) ? MAXD : n;
    aw = 0;
    bw = 0;
    for (int i = 0; i < m; i++) begin
      aw = aw * 4 + da[i];
      bw = bw * 4 + db[i];
    end
    p_eq = (aw == bw);
    p_gt = (aw > bw);
    p_lt = (aw < bw);
    p_err = !use_last;
    p_cnt = m;
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".ready_in_done"}, 32'(din_ready), 0);
    chk_held({tag, ".res"});
    chk({tag, ".err"}, 32'(err), 32'(p_err));
    chk({tag, ".cnt"}, 32'(digit_cnt), 32'(p_cnt));
    start = noise;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".idle_busy"}, 32'(busy), 0);
    chk_held({tag, ".post"});
    chk({tag, ".post_cnt"}, 32'(digit_cnt), 32'(p_cnt));
  endtask

  task automatic set4(input int a0, input int b0, input int a1,
                      input int b1, input int a2, input int b2,
                      input int a3, input int b3);
    da[0] = a0; db[0] = b0; da[1] = a1; db[1] = b1;
    da[2] = a2; db[2] = b2; da[3] = a3; db[3] = b3;
  endtask

  initial begin
    int n;
    bit ul;
    p_eq = 0; p_gt = 0; p_lt = 0; p_err = 0; p_cnt = 0;
    #2;
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    set4(2, 2, 1, 1, 3, 3, 0, 0);
    do_cmp("equal", 4, 0, 1, 0, 0);
    set4(1, 0, 0, 3, 0, 3, 0, 0);
    do_cmp("msb_gt", 3, 0, 1, 0, 0);
    set4(2, 2, 0, 1, 0, 0, 0, 0);
    do_cmp("lsb_lt", 2, 0, 1, 0, 0);

    for (int i = 0; i < MAXD; i++) begin
      da[i] = 1;
      db[i] = 1;
    end
    do_cmp("overflow", MAXD, 0, 0, 0, 0);

    set4(3, 3, 0, 2, 1, 0, 2, 3);
    do_cmp("stall_nogap", 4, 0, 1, 0, 0);
    do_cmp("stall_gap", 4, 3, 1, 1, 0);

    // din_valid alone in IDLE is ignored
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid.ready", 32'(din_ready), 0);
    chk("idle_valid.cnt", 32'(digit_cnt), 32'(p_cnt));
    din_valid = 1'b0;

    set4(3, 3, 1, 1, 2, 2, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_dig = 2'(da[i]);
      b_dig = 2'(db[i]);
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    chk_zero("midrun_reset");
    p_eq = 0; p_gt = 0; p_lt = 0; p_err = 0; p_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_reset.done", 32'(done), 0);
      chk("after_reset.busy", 32'(busy), 0);
    end
    set4(3, 1, 0, 0, 0, 0, 0, 0);
    do_cmp("restart", 1, 0, 1, 0, 0);
    chk("restart.agtb", 32'(agtb), 1);

    set4(0, 2, 0, 0, 0, 0, 0, 0);
    do_cmp("start_with_valid", 1, 0, 1, 0, 1);
    chk("start_with_valid.cnt", 32'(digit_cnt), 1);

    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, MAXD);
      ul = (n < MAXD) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < n; i++) begin
        da[i] = $urandom_range(0, 3);
        db[i] = ($urandom_range(0, 2) == 0) ?
                $urandom_range(0, 3) : da[i];
      end
      do_cmp($sformatf("rand%0d", t), n,
             $urandom_range(0, 2), ul, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
